// File: rtl/col_parity_pkg.sv
// Shared constants and state encoding for the column-parity sequencer.
package col_parity_pkg;

  localparam int unsigned CP_WIDTH = 25;
  localparam int unsigned CP_DEPTH = 64;
  localparam int unsigned CP_AW    = 6;

  localparam logic [CP_AW-1:0] WRAP_ADDR = CP_AW'(CP_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    PRIME,
    PRIME_W,
    LOAD,
    LOAD_W,
    LAUNCH,
    WAIT,
    STORE,
    DONE
  } cp_state_e;

endpackage

// File: rtl/col_parity_wait_timer.sv
// Loadable up-counter with clear/enable; flags expiry once the count reaches TIMEOUT.
module col_parity_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic [CW-1:0] count,
  output logic          expired
);

  assign expired = (count == CW'(TIMEOUT));

  // Holds at TIMEOUT instead of wrapping, so expiry stays asserted until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/col_parity_seq.sv
// Streams every slice and its wrap-around predecessor through the column-parity
// datapath, one launch per slice, and writes each result to the result memory.
module col_parity_seq
  import col_parity_pkg::*;
#(
  parameter int unsigned WIDTH   = CP_WIDTH,
  parameter int unsigned DEPTH   = CP_DEPTH,
  parameter int unsigned AW      = CP_AW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    slice_idx,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_curr,
  output logic [WIDTH-1:0] dp_pre,
  input  logic             dp_ready,
  input  logic [WIDTH-1:0] dp_out,
  output logic             res_we,
  output logic [AW-1:0]    res_addr,
  output logic [WIDTH-1:0] res_wdata
);

  localparam int unsigned     TCW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  cp_state_e        state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cur_q, cur_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [TCW-1:0]   wait_cnt;
  logic             tmr_expired;

  col_parity_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (TCW)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .ld      (1'b0),
    .ld_val  ('0),
    .count   (wait_cnt),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      err_q   <= 1'b0;
      pre_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
      pre_q   <= pre_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    err_d     = err_q;
    pre_d     = pre_q;
    cur_d     = cur_q;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    dp_start  = 1'b0;
    res_we    = 1'b0;
    res_addr  = '0;
    res_wdata = '0;
    done      = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          k_d     = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        mem_rd   = 1'b1;
        mem_addr = LAST_IDX;
        state_d  = PRIME_W;
      end
      PRIME_W: begin
        pre_d   = mem_rdata;
        state_d = LOAD;
      end
      LOAD: begin
        mem_rd   = 1'b1;
        mem_addr = k_q;
        state_d  = LOAD_W;
      end
      LOAD_W: begin
        cur_d   = mem_rdata;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        dp_start = 1'b1;
        tmr_clr  = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        // A zero count marks the first WAIT cycle, where ready may still be stale.
        if ((wait_cnt != '0) && dp_ready) begin
          state_d = STORE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      STORE: begin
        res_we    = 1'b1;
        res_addr  = k_q;
        res_wdata = dp_out;
        if (k_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          pre_d   = cur_q;
          k_d     = k_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign slice_idx = k_q;
  assign dp_curr   = cur_q;
  assign dp_pre    = pre_q;

endmodule

// File: tb/tb_col_parity_seq.sv
// Scoreboard bench for col_parity_seq: mock slice/result memories and a mock
// XOR datapath with selectable ready behaviour.
`timescale 1ns/1ps
module tb_col_parity_seq;
  import col_parity_pkg::*;

  localparam int unsigned W   = 25;
  localparam int unsigned D   = 64;
  localparam int unsigned A   = 6;
  localparam int unsigned TMO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic [A-1:0] slice_idx;
  logic         mem_rd;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_rdata = '0;
  logic         dp_start;
  logic [W-1:0] dp_curr, dp_pre;
  logic         dp_ready;
  logic [W-1:0] dp_out;
  logic         res_we;
  logic [A-1:0] res_addr;
  logic [W-1:0] res_wdata;

  always #5 clk = ~clk;

  col_parity_seq #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AW      (A),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .slice_idx (slice_idx),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dp_start  (dp_start),
    .dp_curr   (dp_curr),
    .dp_pre    (dp_pre),
    .dp_ready  (dp_ready),
    .dp_out    (dp_out),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_wdata (res_wdata)
  );

  // Mock memories and datapath (latency 2 in mode 0, ready stuck 1 / stuck 0 in modes 1 / 2)
  logic [W-1:0] mem [D];
  int           rdy_mode = 0;
  logic         p1 = 1'b0, p2 = 1'b0;
  int           cyc = 0;
  int           wr_cnt = 0;
  logic [A-1:0] last_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    p1 <= dp_start;
    p2 <= p1;
    if (res_we) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= res_addr;
    end
  end

  assign dp_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : p2;
  assign dp_out   = dp_curr ^ dp_pre;

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Run monitor
  bit           done_seen, launch_seen, wr_seen;
  int           done_cyc, wr1_cyc, run_t0, wr_base;
  logic         done_err;
  logic [W-1:0] first_pre, first_cur;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (res_we) begin
      if (!wr_seen) begin
        wr_seen = 1'b1;
        wr1_cyc = cyc;
      end
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("res_addr", 32'(res_addr), 32'(mon_e.addr));
        check("res_wdata", 32'(res_wdata), 32'(mon_e.data));
      end
    end
    if (dp_start && !launch_seen) begin
      launch_seen = 1'b1;
      first_pre   = dp_pre;
      first_cur   = dp_curr;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      done_err  = err;
    end
  end

  task automatic push_expected();
    for (int k = 0; k < int'(D); k++)
      sb.push_back('{addr: A'(k), data: mem[k] ^ mem[(k + int'(D) - 1) % int'(D)]});
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < int'(D); i++)
      mem[i] = (kind == 0) ? W'(i) : W'($urandom);
  endtask

  task automatic start_run(input bit poke_busy, input int abort_at);
    bit hit;
    done_seen   = 1'b0;
    launch_seen = 1'b0;
    wr_seen     = 1'b0;
    wr_base     = wr_cnt;
    @(negedge clk);
    start  = 1'b1;
    run_t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", 32'(err), 0);
    check("busy_on", 32'(busy), 1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !done_seen && !hit; i++) begin
      @(negedge clk);
      start = poke_busy && ((cyc - run_t0 == 10) || (cyc - run_t0 == 200));
      if (abort_at >= 0 && res_we && int'(res_addr) == abort_at) begin
        #2 rst = 1'b0;
        hit = 1'b1;
      end
    end
    start = 1'b0;
    if (abort_at >= 0) check("abort_reached", 32'(hit), 1);
  endtask

  task automatic post_run(input string tag, input int exp_wr, input bit exp_err);
    check({tag, "_done_seen"}, 32'(done_seen), 1);
    check({tag, "_err"}, 32'(done_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_busy_off"}, 32'(busy), 0);
    check({tag, "_writes"}, 32'(wr_cnt - wr_base), 32'(exp_wr));
    check({tag, "_sb_left"}, 32'(sb.size()), 0);
  endtask

  initial begin
    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_dp_start", 32'(dp_start), 0);
    check("rst_res_we", 32'(res_we), 0);
    check("rst_dp_curr", 32'(dp_curr), 0);
    check("rst_dp_pre", 32'(dp_pre), 0);
    check("rst_res_wdata", 32'(res_wdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_res_addr", 32'(res_addr), 0);
    check("rst_slice_idx", 32'(slice_idx), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Nominal run, memory[i] = i
    fill_mem(0);
    rdy_mode = 0;
    push_expected();
    start_run(1'b0, -1);
    check("nom_done_cyc", 32'(done_cyc - run_t0), 387);
    check("nom_first_wr", 32'(wr1_cyc - run_t0), 8);
    post_run("nom", 64, 1'b0);

    // Stale ready held high: still 6 cycles per slice
    fill_mem(1);
    rdy_mode = 1;
    push_expected();
    start_run(1'b0, -1);
    check("stale_done_cyc", 32'(done_cyc - run_t0), 387);
    check("stale_first_wr", 32'(wr1_cyc - run_t0), 8);
    post_run("stale", 64, 1'b0);

    // Timeout: no ready at all
    rdy_mode = 2;
    start_run(1'b0, -1);
    check("to_bounded", 32'((done_cyc - run_t0) <= 20), 1);
    check("to_err_sticky", 32'(err), 1);
    post_run("to", 0, 1'b1);

    // Next start clears err and runs normally
    rdy_mode = 0;
    fill_mem(0);
    push_expected();
    start_run(1'b0, -1);
    check("rerun_done_cyc", 32'(done_cyc - run_t0), 387);
    post_run("rerun", 64, 1'b0);

    // Start pulses while busy are ignored
    fill_mem(1);
    push_expected();
    start_run(1'b1, -1);
    check("poke_done_cyc", 32'(done_cyc - run_t0), 387);
    post_run("poke", 64, 1'b0);

    // Reset during STORE of slice 20
    fill_mem(1);
    push_expected();
    start_run(1'b0, 20);
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_res_we", 32'(res_we), 0);
    check("abort_dp_curr", 32'(dp_curr), 0);
    check("abort_dp_pre", 32'(dp_pre), 0);
    check("abort_slice_idx", 32'(slice_idx), 0);
    check("abort_res_addr", 32'(res_addr), 0);
    repeat (2) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - wr_base), 20);
    check("abort_last_addr", 32'(last_addr), 19);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    push_expected();
    start_run(1'b0, -1);
    check("post_abort_done_cyc", 32'(done_cyc - run_t0), 387);
    post_run("post_abort", 64, 1'b0);

    // Wrap-around predecessor of slice 0
    fill_mem(1);
    mem[D-1] = '1;
    mem[0]   = '0;
    push_expected();
    start_run(1'b0, -1);
    check("wrap_launch_seen", 32'(launch_seen), 1);
    check("wrap_first_pre", 32'(first_pre), 32'h1FF_FFFF);
    check("wrap_first_cur", 32'(first_cur), 0);
    post_run("wrap", 64, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
